// File: rtl/cpu_clk_seq_pkg.sv
// Shared mode encodings, sequencer state type and a busy-state helper for the
// CPU clock sequencer.
package cpu_clk_seq_pkg;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStepWait,
        StBurst,
        StBpHalt
    } state_e;

    // States in which rising CPU clock edges may be issued.
    function automatic logic is_busy(state_e s);
        return (s == StRun) || (s == StStepWait) || (s == StBurst);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Free-running half-period counter: fires toggle_evt once every DIV_HALF+1 sysclk cycles.
module clk_div_core #(
    parameter int unsigned DIV_HALF = 50,
    parameter int unsigned CNT_W    = 8
) (
    input  logic sysclk,
    input  logic reset,
    output logic toggle_evt
);

    logic [CNT_W-1:0] cnt_q;

    assign toggle_evt = (cnt_q == CNT_W'(DIV_HALF));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (toggle_evt) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_clk_sequencer.sv
// Debug CPU clock controller: gates the divided clock per CPU cycle for free-run,
// single-step, N-cycle burst and breakpoint halt.
module cpu_clk_sequencer
    import cpu_clk_seq_pkg::*;
#(
    parameter int unsigned DIV_HALF = 50,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned BURST_W  = 16
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic               step_req,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               bp_hit,
    output logic               cpu_clk,
    output logic               cpu_tick,
    output logic               busy,
    output logic               bp_halted,
    output logic [31:0]        cycle_cnt
);

    logic               toggle_evt;
    logic               step_edge;
    logic               cpu_clk_q;
    logic               cpu_tick_q;
    logic               step_prev_q;
    logic [31:0]        cycle_cnt_q;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    state_e             state_q, state_d;

    clk_div_core #(
        .DIV_HALF (DIV_HALF),
        .CNT_W    (CNT_W)
    ) u_div (
        .sysclk     (sysclk),
        .reset      (reset),
        .toggle_evt (toggle_evt)
    );

    assign step_edge = step_req & ~step_prev_q;

    // High phase always completes; a rising edge needs the pre-update state to grant it.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cpu_clk_q   <= 1'b0;
            cpu_tick_q  <= 1'b0;
            cycle_cnt_q <= '0;
            step_prev_q <= 1'b1;
        end else begin
            step_prev_q <= step_req;
            cpu_tick_q  <= 1'b0;
            if (toggle_evt) begin
                if (cpu_clk_q) begin
                    cpu_clk_q <= 1'b0;
                end else if (busy) begin
                    cpu_clk_q   <= 1'b1;
                    cpu_tick_q  <= 1'b1;
                    cycle_cnt_q <= cycle_cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // bp_hit is only meaningful in the cpu_tick cycle and takes priority there.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StIdle: begin
                case (mode)
                    MODE_HALT: ;
                    MODE_RUN: state_d = StRun;
                    MODE_STEP: if (step_edge) state_d = StStepWait;
                    MODE_BURST: begin
                        if (step_edge && burst_len != '0) begin
                            state_d     = StBurst;
                            remaining_d = burst_len;
                        end
                    end
                endcase
            end
            StRun: begin
                if (cpu_tick_q && bp_hit) begin
                    state_d = StBpHalt;
                end else if (mode != MODE_RUN) begin
                    state_d = StIdle;
                end
            end
            StStepWait: begin
                if (cpu_tick_q) state_d = bp_hit ? StBpHalt : StIdle;
            end
            StBurst: begin
                if (cpu_tick_q && bp_hit) begin
                    state_d     = StBpHalt;
                    remaining_d = remaining_q - BURST_W'(1);
                end else if (mode != MODE_BURST) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (cpu_tick_q) begin
                    remaining_d = remaining_q - BURST_W'(1);
                    if (remaining_q == BURST_W'(1)) state_d = StIdle;
                end
            end
            StBpHalt: begin
                if (step_edge) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = is_busy(state_q);
        bp_halted = (state_q == StBpHalt);
    end

    assign cpu_clk   = cpu_clk_q;
    assign cpu_tick  = cpu_tick_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Bench for cpu_clk_sequencer: directed scenarios plus randomized traffic against a
// command-budget reference model.
module tb_cpu_clk_sequencer;
    import cpu_clk_seq_pkg::*;

    localparam int unsigned D   = 3;
    localparam int unsigned PER = 2 * (D + 1);

    logic        sysclk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        step_req;
    logic [15:0] burst_len;
    logic        bp_hit;
    logic        cpu_clk;
    logic        cpu_tick;
    logic        busy;
    logic        bp_halted;
    logic [31:0] cycle_cnt;

    int checks = 0;
    int errors = 0;
    int tick_total = 0;

    cpu_clk_sequencer #(
        .DIV_HALF (D),
        .CNT_W    (8),
        .BURST_W  (16)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .mode      (mode),
        .step_req  (step_req),
        .burst_len (burst_len),
        .bp_hit    (bp_hit),
        .cpu_clk   (cpu_clk),
        .cpu_tick  (cpu_tick),
        .busy      (busy),
        .bp_halted (bp_halted),
        .cycle_cnt (cycle_cnt)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (cpu_tick === 1'b1) tick_total = tick_total + 1;
    end

    // Reference model: a command holds a budget of rising edges (-1 = unlimited) that
    // the divider timeline spends; RUN/BURST budgets are cancelled by a mode change.
    int unsigned m_k;
    bit          m_clk, m_tick, m_halt, m_prev, m_edge, m_old_tick;
    logic [31:0] m_cnt;
    int          m_permit;
    logic [1:0]  m_cmd;

    always @(posedge sysclk) begin
        if (reset) begin
            m_k = 0; m_clk = 0; m_tick = 0; m_cnt = 0; m_permit = 0;
            m_cmd = MODE_HALT; m_halt = 0; m_prev = 1;
        end else begin
            m_old_tick = m_tick;
            m_edge     = step_req && !m_prev;
            m_k        = m_k + 1;
            m_tick     = 0;
            if (m_k % (D + 1) == 0) begin
                if (m_clk) begin
                    m_clk = 0;
                end else if (m_permit != 0) begin
                    m_clk = 1; m_tick = 1; m_cnt = m_cnt + 1;
                end
            end
            if (m_halt) begin
                if (m_edge) m_halt = 0;
            end else if (m_permit == 0) begin
                if (mode == MODE_RUN) begin
                    m_permit = -1; m_cmd = MODE_RUN;
                end else if (mode == MODE_STEP && m_edge) begin
                    m_permit = 1; m_cmd = MODE_STEP;
                end else if (mode == MODE_BURST && m_edge && burst_len != 0) begin
                    m_permit = int'(burst_len); m_cmd = MODE_BURST;
                end
            end else if (m_old_tick && bp_hit) begin
                m_permit = 0; m_halt = 1;
            end else begin
                if (m_old_tick && m_permit > 0) m_permit = m_permit - 1;
                if (m_permit != 0 && m_cmd != MODE_STEP && mode != m_cmd) m_permit = 0;
            end
            m_prev = step_req;
        end
    end

    task automatic do_reset();
        @(negedge sysclk); reset = 1'b1;
        @(negedge sysclk); @(negedge sysclk); reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic pulse_step();
        step_req = 1'b1; @(negedge sysclk); step_req = 1'b0;
    endtask

    task automatic test_reset();
        int base, busy_seen;
        mode = MODE_RUN; step_req = 1'b0; bp_hit = 1'b0; burst_len = 16'd0;
        reset = 1'b1;
        idle(2);
        checks++;
        if ({cpu_clk, cpu_tick, busy, bp_halted, cycle_cnt} !== 36'd0) begin
            errors++;
            $display("FAIL reset_values got clk=%b tick=%b busy=%b halt=%b cnt=%0d want all 0",
                     cpu_clk, cpu_tick, busy, bp_halted, cycle_cnt);
        end
        // Button held through reset must not count as an edge.
        mode = MODE_STEP; step_req = 1'b1;
        idle(2); reset = 1'b0;
        base = tick_total; busy_seen = 0;
        for (int k = 0; k < 3 * PER; k++) begin
            @(negedge sysclk);
            if (busy) busy_seen = 1;
        end
        checks++;
        if (tick_total - base !== 0 || cycle_cnt !== 0 || busy_seen !== 0) begin
            errors++;
            $display("FAIL held_step_reset got ticks=%0d cnt=%0d busy_seen=%0d want 0 0 0",
                     tick_total - base, cycle_cnt, busy_seen);
        end
        step_req = 1'b0;
    endtask

    task automatic test_run();
        int rises, first, last, mism;
        logic prev;
        mode = MODE_RUN;
        @(negedge sysclk); reset = 1'b1;
        idle(2); reset = 1'b0;
        prev = 1'b0; rises = 0; first = 0; last = 0; mism = 0;
        for (int k = 1; k <= 200 && rises < 10; k++) begin
            @(negedge sysclk);
            if (cpu_tick !== (cpu_clk && !prev)) mism++;
            if (cpu_clk && !prev) begin
                rises++;
                if (rises == 1) first = k;
                last = k;
            end
            prev = cpu_clk;
        end
        checks++;
        if (first !== 4) begin
            errors++; $display("FAIL run_first_rise got %0d want 4", first);
        end
        checks++;
        if (last - first !== 9 * PER) begin
            errors++; $display("FAIL run_period got %0d want %0d", last - first, 9 * PER);
        end
        checks++;
        if (mism !== 0) begin
            errors++; $display("FAIL run_tick_align got %0d misaligned want 0", mism);
        end
        checks++;
        if (cycle_cnt !== 32'd10) begin
            errors++; $display("FAIL run_cycle_cnt got %0d want 10", cycle_cnt);
        end
    endtask

    task automatic test_step();
        int base, lat, busy_seen;
        mode = MODE_STEP; step_req = 1'b0;
        do_reset(); idle(3);
        base = tick_total; lat = -1; busy_seen = 0;
        step_req = 1'b1;
        for (int k = 1; k <= 3 * PER; k++) begin
            @(negedge sysclk);
            if (k == 1) step_req = 1'b0;
            if (busy) busy_seen = 1;
            if (cpu_tick && lat < 0) lat = k;
        end
        checks++;
        if (lat < 1 || lat > int'(PER)) begin
            errors++; $display("FAIL step_latency got %0d want 1..%0d", lat, PER);
        end
        checks++;
        if (tick_total - base !== 1 || cycle_cnt !== 1 || busy !== 0 || busy_seen !== 1) begin
            errors++;
            $display("FAIL step_single got ticks=%0d cnt=%0d busy=%b seen=%0d want 1 1 0 1",
                     tick_total - base, cycle_cnt, busy, busy_seen);
        end
        pulse_step(); idle(3 * PER);
        checks++;
        if (cycle_cnt !== 32'd2) begin
            errors++; $display("FAIL step_second got %0d want 2", cycle_cnt);
        end
    endtask

    task automatic test_burst();
        int base, busy_seen, k;
        mode = MODE_BURST; burst_len = 16'd5;
        do_reset(); idle(2);
        base = tick_total;
        pulse_step();
        for (k = 0; k < 200 && busy; k++) @(negedge sysclk);
        idle(2 * PER);
        checks++;
        if (k >= 200 || tick_total - base !== 5 || cycle_cnt !== 5 || busy !== 0) begin
            errors++;
            $display("FAIL burst_five got ticks=%0d cnt=%0d busy=%b want 5 5 0",
                     tick_total - base, cycle_cnt, busy);
        end
        burst_len = 16'd0; base = tick_total; busy_seen = 0;
        pulse_step();
        for (int j = 0; j < 3 * PER; j++) begin
            @(negedge sysclk);
            if (busy) busy_seen = 1;
        end
        checks++;
        if (tick_total - base !== 0 || busy_seen !== 0) begin
            errors++;
            $display("FAIL burst_zero got ticks=%0d busy_seen=%0d want 0 0",
                     tick_total - base, busy_seen);
        end
    endtask

    task automatic test_bp_run();
        int base, n;
        mode = MODE_RUN; bp_hit = 1'b0;
        do_reset();
        base = tick_total; n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            @(negedge sysclk);
            if (cpu_tick) begin
                n++;
                if (n == 3) bp_hit = 1'b1;
            end
        end
        @(negedge sysclk); bp_hit = 1'b0;
        idle(3 * PER);
        checks++;
        if (n !== 3 || tick_total - base !== 3 || bp_halted !== 1 || cpu_clk !== 0 || busy !== 0)
        begin
            errors++;
            $display("FAIL bp_run_halt got ticks=%0d halt=%b clk=%b busy=%b want 3 1 0 0",
                     tick_total - base, bp_halted, cpu_clk, busy);
        end
        pulse_step();
        checks++;
        if (bp_halted !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL bp_release got halt=%b busy=%b want 0 0", bp_halted, busy);
        end
        idle(3 * PER);
        checks++;
        if (busy !== 1 || tick_total - base < 4) begin
            errors++;
            $display("FAIL bp_resume got busy=%b ticks=%0d want 1 >=4", busy, tick_total - base);
        end
    endtask

    task automatic test_burst_bp_abort();
        int base, n, high;
        mode = MODE_BURST; burst_len = 16'd4; bp_hit = 1'b0;
        do_reset(); idle(2);
        base = tick_total; n = 0;
        pulse_step();
        for (int k = 0; k < 200 && n < 4; k++) begin
            @(negedge sysclk);
            if (cpu_tick) begin
                n++;
                if (n == 4) bp_hit = 1'b1;
            end
        end
        @(negedge sysclk); bp_hit = 1'b0;
        idle(2 * PER);
        checks++;
        if (tick_total - base !== 4 || bp_halted !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL burst_bp_last got ticks=%0d halt=%b busy=%b want 4 1 0",
                     tick_total - base, bp_halted, busy);
        end
        burst_len = 16'd10;
        do_reset(); idle(2);
        base = tick_total; n = 0;
        pulse_step();
        for (int k = 0; k < 200 && n < 2; k++) begin
            @(negedge sysclk);
            if (cpu_tick) begin
                n++;
                if (n == 2) mode = MODE_HALT;
            end
        end
        high = 1;
        for (int k = 0; k < 2 * PER; k++) begin
            @(negedge sysclk);
            if (cpu_clk) high++;
        end
        checks++;
        if (high !== int'(D + 1)) begin
            errors++; $display("FAIL abort_high_phase got %0d want %0d", high, D + 1);
        end
        idle(2 * PER);
        checks++;
        if (tick_total - base !== 2 || cycle_cnt !== 2 || busy !== 0 || cpu_clk !== 0) begin
            errors++;
            $display("FAIL burst_abort got ticks=%0d cnt=%0d busy=%b clk=%b want 2 2 0 0",
                     tick_total - base, cycle_cnt, busy, cpu_clk);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        mode = MODE_RUN;
        do_reset();
        for (k = 0; k < 100 && !cpu_clk; k++) @(negedge sysclk);
        @(negedge sysclk);
        checks++;
        if (k >= 100 || cpu_clk !== 1) begin
            errors++; $display("FAIL mid_reset_setup got clk=%b want 1", cpu_clk);
        end
        reset = 1'b1;
        @(negedge sysclk);
        checks++;
        if (cpu_clk !== 0 || cycle_cnt !== 0 || busy !== 0 || bp_halted !== 0) begin
            errors++;
            $display("FAIL mid_reset got clk=%b cnt=%0d busy=%b halt=%b want 0 0 0 0",
                     cpu_clk, cycle_cnt, busy, bp_halted);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [35:0] got, exp;
        mode = MODE_RUN; step_req = 1'b0; bp_hit = 1'b0; burst_len = 16'd3;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge sysclk);
            got = {cpu_clk, cpu_tick, busy, bp_halted, cycle_cnt};
            exp = {m_clk, m_tick, (m_permit != 0), m_halt, m_cnt};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cycle %0d got clk/tick/busy/halt/cnt=%h want %h", i, got, exp);
            end
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) step_req = ~step_req;
            bp_hit = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) burst_len = 16'($urandom_range(0, 6));
            reset = ($urandom_range(0, 999) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mode = MODE_HALT; step_req = 1'b0; bp_hit = 1'b0; burst_len = 16'd0;
        test_reset();
        test_run();
        test_step();
        test_burst();
        test_bp_run();
        test_burst_bp_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
